// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter
//   Two requesters share one binary-to-Gray conversion stage. Each cycle an
//   arbiter grants at most one valid requester. The winner's word is converted
//   to Gray code (g = b ^ (b >> 1)) and captured in a single registered output
//   stage. That stage holds the result and the winner's ID until the consumer
//   accepts it.
//
//   Optional feature macro: ROUND_ROBIN_EN
//     defined   - a tie alternates between requesters (round robin)
//     undefined - a tie always goes to requester 0 (fixed priority)
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous reset, active low
//   req0_valid   requester 0 offers req0_bin
//   req0_bin     requester 0 binary word [WIDTH]
//   req0_ready   requester 0 word accepted this cycle
//   req1_valid   requester 1 offers req1_bin
//   req1_bin     requester 1 binary word [WIDTH]
//   req1_ready   requester 1 word accepted this cycle
//   out_valid    out_gray / out_id hold a result
//   out_gray     Gray-coded result [WIDTH]
//   out_id       requester that produced out_gray
//   out_ready    downstream accepts the result
//   done_cnt     completed output handshakes, wraps [CNT_W]

module gray_conv_arbiter #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_bin,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_bin,
   output logic             req1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_gray,
   output logic             out_id,
   input  logic             out_ready,
   output logic [CNT_W-1:0] done_cnt
);

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_gray;
   logic             r_out_id;
   logic [CNT_W-1:0] r_done_cnt;

   logic             w_load;
   logic             w_grant0;
   logic             w_grant1;
   logic             w_accept;
   logic             w_out_hs;
   logic [WIDTH-1:0] w_sel_bin;
   logic [WIDTH-1:0] w_gray;

   // The output stage can take a new word when it is empty or is being
   // drained in this same cycle. This gives full throughput.
   assign w_load   = ~r_out_valid | out_ready;
   assign w_out_hs = r_out_valid & out_ready;

`ifdef ROUND_ROBIN_EN
   // last holds the most recently accepted requester. On a tie the other
   // requester wins. The reset value 1 makes requester 0 win the first tie.
   logic r_last;

   assign w_grant0 = req0_valid & (~req1_valid | r_last);
   assign w_grant1 = req1_valid & (~req0_valid | ~r_last);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last <= 1'b1;
      end else if (w_accept) begin
         r_last <= w_grant1;
      end
   end
`else
   // Fixed priority: requester 0 always wins a tie.
   assign w_grant0 = req0_valid;
   assign w_grant1 = req1_valid & ~req0_valid;
`endif

   // The grants are mutually exclusive and each depends on its own valid,
   // so at most one ready is high, and only toward a valid requester.
   assign req0_ready = w_load & w_grant0;
   assign req1_ready = w_load & w_grant1;
   assign w_accept   = req0_ready | req1_ready;

   assign w_sel_bin  = w_grant1 ? req1_bin : req0_bin;

   // Gray conversion: the MSB passes through and each lower bit is the XOR of
   // itself and its upper neighbour.
   assign w_gray[WIDTH-1] = w_sel_bin[WIDTH-1];
   generate
      for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
         assign w_gray[gi] = w_sel_bin[gi+1] ^ w_sel_bin[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_gray  <= '0;
         r_out_id    <= 1'b0;
         r_done_cnt  <= '0;
      end else begin
         if (w_out_hs) begin
            r_done_cnt <= r_done_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         // A new accept overrides the drain, so a simultaneous handshake and
         // accept keeps out_valid high with the fresh result.
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_gray  <= w_gray;
            r_out_id    <= w_grant1;
         end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_gray  = r_out_gray;
   assign out_id    = r_out_id;
   assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
module tb_gray_conv_arbiter;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req0_valid = 1'b0;
   logic [WIDTH-1:0] req0_bin = '0;
   logic             req0_ready;
   logic             req1_valid = 1'b0;
   logic [WIDTH-1:0] req1_bin = '0;
   logic             req1_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_gray;
   logic             out_id;
   logic             out_ready = 1'b0;
   logic [CNT_W-1:0] done_cnt;

   gray_conv_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_bin   (req0_bin),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_bin   (req1_bin),
      .req1_ready (req1_ready),
      .out_valid  (out_valid),
      .out_gray   (out_gray),
      .out_id     (out_id),
      .out_ready  (out_ready),
      .done_cnt   (done_cnt)
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Reference model: the contents of the output slot plus a plain integer
   // handshake counter and the last-winner pointer.
   bit               m_valid = 1'b0;
   logic [WIDTH-1:0] m_gray  = '0;
   bit               m_id    = 1'b0;
   int               m_cnt   = 0;
   int               m_last  = 1;

`ifdef ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   // Winner under the current inputs: -1 for none, else the requester index.
   function automatic int model_grant();
      if (m_valid && !out_ready) return -1;
      if (req0_valid && !req1_valid) return 0;
      if (req1_valid && !req0_valid) return 1;
      if (req0_valid && req1_valid) return RR ? (1 - m_last) : 0;
      return -1;
   endfunction

   function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Advance one clock and step the model with the inputs sampled at that edge.
   task automatic cycle();
      int g;
      logic [WIDTH-1:0] b;
      g = model_grant();
      @(posedge clk);
      if (!rst_n) begin
         m_valid = 1'b0; m_gray = '0; m_id = 1'b0; m_cnt = 0; m_last = 1;
      end else begin
         if (m_valid && out_ready) m_cnt = (m_cnt + 1) % (1 << CNT_W);
         if (g >= 0) begin
            b = (g == 1) ? req1_bin : req0_bin;
            m_gray = to_gray(b); m_id = (g == 1); m_valid = 1'b1; m_last = g;
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
      cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
      cycle(); cycle();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", out_valid); else pass_cnt++;
      total_cnt++; if (out_gray !== 4'd0) $display("FAIL reset_gray got=%h exp=0", out_gray); else pass_cnt++;
      total_cnt++; if (out_id !== 1'b0) $display("FAIL reset_id got=%0b exp=0", out_id); else pass_cnt++;
      total_cnt++; if (done_cnt !== 8'd0) $display("FAIL reset_cnt got=%0d exp=0", done_cnt); else pass_cnt++;
      rst_n = 1'b1;
      $display("txn reset");
   endtask

   task automatic test_basic();
      req0_valid = 1'b1; req0_bin = 4'b0110; out_ready = 1'b1;
      #1;
      total_cnt++; if (req0_ready !== 1'b1) $display("FAIL basic_ready0 got=%0b exp=1", req0_ready); else pass_cnt++;
      total_cnt++; if (req1_ready !== 1'b0) $display("FAIL basic_ready1 got=%0b exp=0", req1_ready); else pass_cnt++;
      cycle();
      req0_valid = 1'b0;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid got=%0b exp=1", out_valid); else pass_cnt++;
      total_cnt++; if (out_gray !== 4'b0101) $display("FAIL basic_gray got=%b exp=0101", out_gray); else pass_cnt++;
      total_cnt++; if (out_id !== 1'b0) $display("FAIL basic_id got=%0b exp=0", out_id); else pass_cnt++;
      $display("txn basic bin=0110 gray=%b id=%0b", out_gray, out_id);
   endtask

   task automatic test_tie();
      bit exp_id;
      do_reset();
      req0_valid = 1'b1; req0_bin = 4'd3; req1_valid = 1'b1; req1_bin = 4'd9; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_id = RR ? i[0] : 1'b0;
         cycle();
         total_cnt++; if (out_id !== exp_id) $display("FAIL tie_id[%0d] got=%0b exp=%0b", i, out_id, exp_id); else pass_cnt++;
         total_cnt++; if (out_gray !== to_gray(exp_id ? 4'd9 : 4'd3)) $display("FAIL tie_gray[%0d] got=%h exp=%h", i, out_gray, to_gray(exp_id ? 4'd9 : 4'd3)); else pass_cnt++;
         $display("txn tie %0d id=%0b gray=%h", i, out_id, out_gray);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      cycle();
      total_cnt++; if (done_cnt !== 8'd4) $display("FAIL tie_cnt got=%0d exp=4", done_cnt); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL tie_drain got=%0b exp=0", out_valid); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] held_gray;
      logic [CNT_W-1:0] held_cnt;
      req1_valid = 1'b1; req1_bin = 4'd12; out_ready = 1'b1;
      cycle();
      held_gray = to_gray(4'd12);
      held_cnt  = done_cnt;
      out_ready = 1'b0; req0_valid = 1'b1; req0_bin = 4'd5; req1_bin = 4'd12;
      for (int i = 0; i < 3; i++) begin
         #1;
         total_cnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL bp_ready[%0d] got=%b exp=00", i, {req0_ready, req1_ready}); else pass_cnt++;
         cycle();
         total_cnt++; if (out_gray !== held_gray || out_id !== 1'b1 || out_valid !== 1'b1) $display("FAIL bp_hold[%0d] got=%h/%0b/%0b exp=%h/1/1", i, out_gray, out_id, out_valid, held_gray); else pass_cnt++;
         total_cnt++; if (done_cnt !== held_cnt) $display("FAIL bp_cnt[%0d] got=%0d exp=%0d", i, done_cnt, held_cnt); else pass_cnt++;
      end
      $display("txn backpressure held gray=%h", out_gray);
      req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
      cycle();
   endtask

   task automatic test_sweep();
      logic [WIDTH-1:0] prev;
      logic [WIDTH-1:0] b;
      req0_valid = 1'b0; req1_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         b = WIDTH'(i);
         req1_bin = b;
         #1;
         total_cnt++; if (req1_ready !== 1'b1) $display("FAIL sweep_ready[%0d] got=%0b exp=1", i, req1_ready); else pass_cnt++;
         cycle();
         total_cnt++; if (out_gray !== (b ^ (b >> 1))) $display("FAIL sweep_gray[%0d] got=%b exp=%b", i, out_gray, b ^ (b >> 1)); else pass_cnt++;
         if (i > 0) begin
            total_cnt++; if ($countones(out_gray ^ prev) != 1) $display("FAIL sweep_step[%0d] got=%b prev=%b exp one-bit change", i, out_gray, prev); else pass_cnt++;
         end
         if (i == 15) begin
            total_cnt++; if (out_gray !== 4'b1000) $display("FAIL sweep_15 got=%b exp=1000", out_gray); else pass_cnt++;
         end
         prev = out_gray;
         $display("txn sweep bin=%0d gray=%b", i, out_gray);
      end
      req1_valid = 1'b0;
      cycle();
   endtask

   task automatic test_wrap();
      do_reset();
      req0_valid = 1'b1; req0_bin = 4'd7; out_ready = 1'b1;
      for (int i = 0; i < 256; i++) cycle();
      total_cnt++; if (done_cnt !== 8'd255) $display("FAIL wrap_255 got=%0d exp=255", done_cnt); else pass_cnt++;
      req0_valid = 1'b0;
      cycle();
      total_cnt++; if (done_cnt !== 8'd0) $display("FAIL wrap_0 got=%0d exp=0", done_cnt); else pass_cnt++;
      $display("txn wrap cnt=%0d", done_cnt);
   endtask

   task automatic test_reset_midflight();
      do_reset();
      req0_valid = 1'b1; req0_bin = 4'd3; out_ready = 1'b0;
      cycle();
      req0_valid = 1'b0;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL mid_loaded got=%0b exp=1", out_valid); else pass_cnt++;
      rst_n = 1'b0;
      cycle();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_valid got=%0b exp=0", out_valid); else pass_cnt++;
      total_cnt++; if (done_cnt !== 8'd0) $display("FAIL mid_cnt got=%0d exp=0", done_cnt); else pass_cnt++;
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_bin = 4'd1; req1_valid = 1'b1; req1_bin = 4'd2; out_ready = 1'b1;
      #1;
      total_cnt++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL mid_tie got=%b exp=01", {req1_ready, req0_ready}); else pass_cnt++;
      cycle();
      total_cnt++; if (out_id !== 1'b0) $display("FAIL mid_id got=%0b exp=0", out_id); else pass_cnt++;
      req0_valid = 1'b0; req1_valid = 1'b0;
      cycle();
      $display("txn reset_midflight");
   endtask

   task automatic test_random();
      bit took0 = 1'b0;
      bit took1 = 1'b0;
      int g;
      for (int i = 0; i < 400; i++) begin
         // A requester may only change its offer once the previous one is taken.
         if (!req0_valid || took0) begin req0_valid = $urandom_range(0, 1) != 0; req0_bin = WIDTH'($urandom); end
         if (!req1_valid || took1) begin req1_valid = $urandom_range(0, 1) != 0; req1_bin = WIDTH'($urandom); end
         out_ready = $urandom_range(0, 3) != 0;
         #1;
         g = model_grant();
         total_cnt++; if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) $display("FAIL rand_ready[%0d] got=%b exp=%b", i, {req1_ready, req0_ready}, {g == 1, g == 0}); else pass_cnt++;
         took0 = (g == 0); took1 = (g == 1);
         cycle();
         total_cnt++; if (out_valid !== m_valid || out_id !== m_id || out_gray !== m_gray) $display("FAIL rand_out[%0d] got=%0b/%0b/%h exp=%0b/%0b/%h", i, out_valid, out_id, out_gray, m_valid, m_id, m_gray); else pass_cnt++;
         total_cnt++; if (done_cnt !== CNT_W'(m_cnt)) $display("FAIL rand_cnt[%0d] got=%0d exp=%0d", i, done_cnt, m_cnt); else pass_cnt++;
         if (g >= 0) $display("txn rand %0d accept id=%0d gray=%h cnt=%0d", i, g, out_gray, done_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tie();
      test_backpressure();
      test_sweep();
      test_wrap();
      test_reset_midflight();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
